// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store controller: RISC-V width codes,
// FSM state encoding and access-size helpers.
package lsu_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        BEAT0 = 3'd1,
        BEAT1 = 3'd2,
        CAPT  = 3'd3,
        RESP  = 3'd4
    } state_t;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    // Size encodings are funct3[1:0].
    localparam logic [1:0] SZ_B = 2'b00;
    localparam logic [1:0] SZ_H = 2'b01;
    localparam logic [1:0] SZ_W = 2'b10;

    function automatic logic [2:0] size_bytes(input logic [1:0] sz);
        case (sz)
            SZ_B:    return 3'd1;
            SZ_H:    return 3'd2;
            default: return 3'd4;
        endcase
    endfunction

    function automatic logic [3:0] size_mask(input logic [1:0] sz);
        case (sz)
            SZ_B:    return 4'b0001;
            SZ_H:    return 4'b0011;
            default: return 4'b1111;
        endcase
    endfunction

    // An access is split when it runs past the end of its first word.
    function automatic logic is_split(input logic [2:0] f3, input logic [1:0] offset);
        return ({2'b00, offset} + {1'b0, size_bytes(f3[1:0])}) > 4'd4;
    endfunction

    function automatic logic bad_funct3(input logic wr, input logic [2:0] f3);
        if (wr)
            return f3 > F3_W;
        return (f3 == 3'b011) || (f3[2:1] == 2'b11);
    endfunction

endpackage

// File: rtl/load_store_ctrl_if.sv
// Request/response and RAM-side signal bundle of the load/store controller.
interface load_store_ctrl_if #(
    parameter int MEM_AW = 9
);
    logic              req_valid;
    logic              req_ready;
    logic              req_wr;
    logic [2:0]        req_funct3;
    logic [31:0]       req_addr;
    logic [31:0]       req_wdata;
    logic              resp_valid;
    logic [31:0]       resp_rdata;
    logic              resp_err;
    logic [MEM_AW-1:0] mem_addr;
    logic [3:0]        mem_be;
    logic              mem_we;
    logic [31:0]       mem_wdata;
    logic [31:0]       mem_rdata;

    // Controller side.
    modport slave (
        input  req_valid, req_wr, req_funct3, req_addr, req_wdata, mem_rdata,
        output req_ready, resp_valid, resp_rdata, resp_err,
               mem_addr, mem_be, mem_we, mem_wdata
    );

    // Requester plus RAM side.
    modport master (
        output req_valid, req_wr, req_funct3, req_addr, req_wdata, mem_rdata,
        input  req_ready, resp_valid, resp_rdata, resp_err,
               mem_addr, mem_be, mem_we, mem_wdata
    );
endinterface

// File: rtl/lsu_align.sv
// Byte-lane steering for the load/store controller: store byte enables and
// data for both beats, and load word merge with sign/zero extension.
module lsu_align
    import lsu_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  offset,
    input  logic [31:0] wdata,
    input  logic [31:0] word0,
    input  logic [31:0] word1,
    output logic [3:0]  be0,
    output logic [3:0]  be1,
    output logic [31:0] wdata0,
    output logic [31:0] wdata1,
    output logic [31:0] rdata
);
    logic [5:0]  bit_shift;
    logic [7:0]  be_wide;
    logic [63:0] wdata_wide;
    logic [31:0] rdata_lo;

    always_comb begin
        // NOTE: every output gets a value on every path, otherwise a latch is inferred.
        bit_shift  = {offset, 3'b000};
        be_wide    = {4'b0000, size_mask(funct3[1:0])} << offset;
        wdata_wide = {32'h0, wdata} << bit_shift;
        rdata_lo   = 32'({word1, word0} >> bit_shift);

        be0    = be_wide[3:0];
        be1    = be_wide[7:4];
        wdata0 = wdata_wide[31:0];
        wdata1 = wdata_wide[63:32];

        case (funct3)
            F3_B:    rdata = {{24{rdata_lo[7]}},  rdata_lo[7:0]};
            F3_H:    rdata = {{16{rdata_lo[15]}}, rdata_lo[15:0]};
            F3_BU:   rdata = {24'h0, rdata_lo[7:0]};
            F3_HU:   rdata = {16'h0, rdata_lo[15:0]};
            default: rdata = rdata_lo;
        endcase
    end
endmodule

// File: rtl/load_store_ctrl.sv
// Load/store controller: turns byte-addressed RISC-V loads/stores into one or
// two beats on a single-port synchronous 32-bit RAM.
module load_store_ctrl
    import lsu_pkg::*;
#(
    parameter int MEM_AW      = 9,
    parameter int MISALIGN_EN = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    load_store_ctrl_if.slave  bus
);
    state_t state, state_nx;

    logic              wr_q;
    logic              err_q;
    logic [2:0]        funct3_q;
    logic [MEM_AW+1:0] addr_q;
    logic [31:0]       wdata_q;
    logic [31:0]       word0_q;
    logic [31:0]       word1_q;

    logic              accept;
    logic              req_illegal;
    logic              split;
    logic [MEM_AW-1:0] word_addr;
    logic [3:0]        be0, be1;
    logic [31:0]       wdata0, wdata1, load_data;
    logic              unused_addr_hi;

    // Address bits above the attached RAM are ignored.
    assign unused_addr_hi = ^bus.req_addr[31:MEM_AW+2];

    assign accept      = (state == IDLE) && bus.req_valid;
    assign req_illegal = bad_funct3(bus.req_wr, bus.req_funct3) ||
                         ((MISALIGN_EN == 0) && is_split(bus.req_funct3, bus.req_addr[1:0]));
    assign split       = is_split(funct3_q, addr_q[1:0]);
    assign word_addr   = addr_q[MEM_AW+1:2];

    lsu_align u_align (
        .funct3 (funct3_q),
        .offset (addr_q[1:0]),
        .wdata  (wdata_q),
        .word0  (word0_q),
        .word1  (word1_q),
        .be0    (be0),
        .be1    (be1),
        .wdata0 (wdata0),
        .wdata1 (wdata1),
        .rdata  (load_data)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments only.
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_q     <= 1'b0;
            err_q    <= 1'b0;
            funct3_q <= 3'b000;
            addr_q   <= '0;
            wdata_q  <= 32'h0;
            word0_q  <= 32'h0;
            word1_q  <= 32'h0;
        end else begin
            if (accept) begin
                wr_q     <= bus.req_wr;
                err_q    <= req_illegal;
                funct3_q <= bus.req_funct3;
                addr_q   <= bus.req_addr[MEM_AW+1:0];
                wdata_q  <= bus.req_wdata;
            end
            // RAM data lags its address by one cycle: word0 shows up in the
            // state after BEAT0, the last word in CAPT.
            if (state == BEAT1)
                word0_q <= bus.mem_rdata;
            if (state == CAPT) begin
                if (split) word1_q <= bus.mem_rdata;
                else       word0_q <= bus.mem_rdata;
            end
        end
    end

    always_comb begin
        state_nx       = state;
        bus.req_ready  = 1'b0;
        bus.resp_valid = 1'b0;
        bus.resp_err   = 1'b0;
        bus.resp_rdata = 32'h0;
        bus.mem_addr   = '0;
        bus.mem_be     = 4'b0000;
        bus.mem_we     = 1'b0;
        bus.mem_wdata  = 32'h0;

        case (state)
            IDLE: begin
                bus.req_ready = 1'b1;
                if (bus.req_valid)
                    state_nx = req_illegal ? RESP : BEAT0;
            end
            BEAT0: begin
                bus.mem_addr  = word_addr;
                bus.mem_be    = be0;
                bus.mem_we    = wr_q;
                bus.mem_wdata = wdata0;
                if (split)     state_nx = BEAT1;
                else if (wr_q) state_nx = RESP;
                else           state_nx = CAPT;
            end
            BEAT1: begin
                bus.mem_addr  = word_addr + MEM_AW'(1);
                bus.mem_be    = be1;
                bus.mem_we    = wr_q;
                bus.mem_wdata = wdata1;
                state_nx      = wr_q ? RESP : CAPT;
            end
            CAPT: begin
                state_nx = RESP;
            end
            RESP: begin
                bus.resp_valid = 1'b1;
                bus.resp_err   = err_q;
                bus.resp_rdata = (wr_q || err_q) ? 32'h0 : load_data;
                state_nx       = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end
endmodule

// File: tb/tb_load_store_ctrl.sv
// Directed self-checking bench for load_store_ctrl: one split-capable instance
// with a behavioural RAM, one MISALIGN_EN=0 instance for rejection cases.
module tb_load_store_ctrl;
    import lsu_pkg::*;

    logic clk;
    logic rst_n;

    load_store_ctrl_if #(.MEM_AW(9)) bus0 ();
    load_store_ctrl_if #(.MEM_AW(9)) bus1 ();

    load_store_ctrl #(.MEM_AW(9), .MISALIGN_EN(1)) dut0 (.clk(clk), .rst_n(rst_n), .bus(bus0));
    load_store_ctrl #(.MEM_AW(9), .MISALIGN_EN(0)) dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));

    int checks   = 0;
    int failures = 0;

    // Shared request drive, steered to one instance by use1.
    logic        use1 = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_wr = 1'b0;
    logic [2:0]  req_funct3 = 3'b000;
    logic [31:0] req_addr = 32'h0;
    logic [31:0] req_wdata = 32'h0;

    assign bus0.req_valid  = req_valid & ~use1;
    assign bus1.req_valid  = req_valid & use1;
    assign bus0.req_wr     = req_wr;
    assign bus1.req_wr     = req_wr;
    assign bus0.req_funct3 = req_funct3;
    assign bus1.req_funct3 = req_funct3;
    assign bus0.req_addr   = req_addr;
    assign bus1.req_addr   = req_addr;
    assign bus0.req_wdata  = req_wdata;
    assign bus1.req_wdata  = req_wdata;
    assign bus1.mem_rdata  = 32'h0;

    logic        o_ready, o_resp_valid, o_err, o_we;
    logic [31:0] o_rdata, o_wdata;
    logic [8:0]  o_mem_addr;
    logic [3:0]  o_be;

    assign o_ready      = use1 ? bus1.req_ready  : bus0.req_ready;
    assign o_resp_valid = use1 ? bus1.resp_valid : bus0.resp_valid;
    assign o_err        = use1 ? bus1.resp_err   : bus0.resp_err;
    assign o_rdata      = use1 ? bus1.resp_rdata : bus0.resp_rdata;
    assign o_mem_addr   = use1 ? bus1.mem_addr   : bus0.mem_addr;
    assign o_be         = use1 ? bus1.mem_be     : bus0.mem_be;
    assign o_we         = use1 ? bus1.mem_we     : bus0.mem_we;
    assign o_wdata      = use1 ? bus1.mem_wdata  : bus0.mem_wdata;

    // Single-port synchronous RAM with byte enables, 1-cycle read latency.
    logic [31:0] ram0 [0:511] = '{default: 32'h0};
    always @(posedge clk) begin
        if (bus0.mem_we)
            for (int b = 0; b < 4; b++)
                if (bus0.mem_be[b]) ram0[bus0.mem_addr][8*b +: 8] <= bus0.mem_wdata[8*b +: 8];
        bus0.mem_rdata <= ram0[bus0.mem_addr];
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Results of the most recent transaction.
    int          lat;
    int          nbeats;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic [8:0]  b_addr [4];
    logic [3:0]  b_be [4];
    logic        b_we [4];
    logic [31:0] b_wdata [4];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // Issues one request and records the beats and the response; lat stays 0
    // if no response arrives within the cycle budget.
    task automatic do_req(input logic sel, input logic wr, input logic [2:0] f3,
                          input logic [31:0] addr, input logic [31:0] wdata);
        use1 = sel;
        @(negedge clk);
        check("req_ready_before_req", 32'(o_ready), 32'd1);
        req_wr     = wr;
        req_funct3 = f3;
        req_addr   = addr;
        req_wdata  = wdata;
        req_valid  = 1'b1;
        @(posedge clk);
        #1 req_valid = 1'b0;
        lat       = 0;
        nbeats    = 0;
        rsp_rdata = 32'h0;
        rsp_err   = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            if (o_be != 4'b0000 || o_we) begin
                if (nbeats < 4) begin
                    b_addr[nbeats]  = o_mem_addr;
                    b_be[nbeats]    = o_be;
                    b_we[nbeats]    = o_we;
                    b_wdata[nbeats] = o_wdata;
                end
                nbeats++;
            end
            if (o_resp_valid) begin
                lat       = k;
                rsp_rdata = o_rdata;
                rsp_err   = o_err;
                break;
            end
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_req_ready"},  32'(bus0.req_ready),  32'd1);
        check({tag, "_resp_valid"}, 32'(bus0.resp_valid), 32'd0);
        check({tag, "_resp_err"},   32'(bus0.resp_err),   32'd0);
        check({tag, "_resp_rdata"}, bus0.resp_rdata,      32'h0);
        check({tag, "_mem_we"},     32'(bus0.mem_we),     32'd0);
        check({tag, "_mem_be"},     32'(bus0.mem_be),     32'd0);
        check({tag, "_mem_addr"},   32'(bus0.mem_addr),   32'd0);
        check({tag, "_mem_wdata"},  bus0.mem_wdata,       32'h0);
    endtask

    initial begin
        rst_n = 1'b0;
        #3;
        check_reset_outputs("por");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // SW 0xDEADBEEF @0x10, then LW back.
        do_req(1'b0, 1'b1, F3_W, 32'h10, 32'hDEADBEEF);
        check("sw10_lat",   32'(lat),    32'd2);
        check("sw10_beats", 32'(nbeats), 32'd1);
        check("sw10_addr",  32'(b_addr[0]), 32'd4);
        check("sw10_be",    32'(b_be[0]),   32'hF);
        check("sw10_we",    32'(b_we[0]),   32'd1);
        check("sw10_wdata", b_wdata[0],     32'hDEADBEEF);
        do_req(1'b0, 1'b0, F3_W, 32'h10, 32'h0);
        check("lw10_lat",   32'(lat),       32'd3);
        check("lw10_rdata", rsp_rdata,      32'hDEADBEEF);
        check("lw10_err",   32'(rsp_err),   32'd0);
        check("lw10_be",    32'(b_be[0]),   32'hF);
        check("lw10_we",    32'(b_we[0]),   32'd0);

        // Word 8 = 0x000080FF, byte/half extension.
        do_req(1'b0, 1'b1, F3_W, 32'h20, 32'h000080FF);
        check("sw20_lat", 32'(lat), 32'd2);
        do_req(1'b0, 1'b0, F3_B, 32'h20, 32'h0);
        check("lb20_rdata", rsp_rdata, 32'hFFFFFFFF);
        check("lb20_lat",   32'(lat),  32'd3);
        do_req(1'b0, 1'b0, F3_BU, 32'h21, 32'h0);
        check("lbu21_rdata", rsp_rdata,     32'h00000080);
        check("lbu21_be",    32'(b_be[0]),  32'b0010);
        check("lbu21_addr",  32'(b_addr[0]), 32'd8);
        do_req(1'b0, 1'b0, F3_H, 32'h20, 32'h0);
        check("lh20_rdata", rsp_rdata, 32'hFFFF80FF);

        // Split word store/load at 0x13.
        do_req(1'b0, 1'b1, F3_W, 32'h13, 32'h11223344);
        check("sw13_lat",    32'(lat),       32'd3);
        check("sw13_beats",  32'(nbeats),    32'd2);
        check("sw13_addr0",  32'(b_addr[0]), 32'd4);
        check("sw13_be0",    32'(b_be[0]),   32'b1000);
        check("sw13_wdata0", b_wdata[0],     32'h44000000);
        check("sw13_addr1",  32'(b_addr[1]), 32'd5);
        check("sw13_be1",    32'(b_be[1]),   32'b0111);
        check("sw13_wdata1", b_wdata[1],     32'h00112233);
        do_req(1'b0, 1'b0, F3_W, 32'h13, 32'h0);
        check("lw13_lat",   32'(lat),   32'd4);
        check("lw13_rdata", rsp_rdata,  32'h11223344);
        check("lw13_beats", 32'(nbeats), 32'd2);

        // Split half at the top of the RAM wraps to word 0.
        do_req(1'b0, 1'b1, F3_H, 32'h7FF, 32'h0000BEEF);
        check("sh7ff_addr0", 32'(b_addr[0]), 32'h1FF);
        check("sh7ff_be0",   32'(b_be[0]),   32'b1000);
        check("sh7ff_addr1", 32'(b_addr[1]), 32'd0);
        check("sh7ff_be1",   32'(b_be[1]),   32'b0001);
        check("sh7ff_lat",   32'(lat),       32'd3);
        do_req(1'b0, 1'b0, F3_H, 32'h7FF, 32'h0);
        check("lh7ff_addr1", 32'(b_addr[1]), 32'd0);
        check("lh7ff_rdata", rsp_rdata,      32'hFFFFBEEF);
        check("lh7ff_lat",   32'(lat),       32'd4);

        // Illegal width codes.
        do_req(1'b0, 1'b0, 3'b011, 32'h40, 32'h0);
        check("ld011_lat",   32'(lat),     32'd1);
        check("ld011_err",   32'(rsp_err), 32'd1);
        check("ld011_rdata", rsp_rdata,    32'h0);
        check("ld011_beats", 32'(nbeats),  32'd0);
        do_req(1'b0, 1'b1, 3'b100, 32'h40, 32'h12345678);
        check("st100_lat",   32'(lat),     32'd1);
        check("st100_err",   32'(rsp_err), 32'd1);
        check("st100_beats", 32'(nbeats),  32'd0);
        do_req(1'b0, 1'b0, F3_W, 32'h10, 32'h0);
        check("lw10_after_split", rsp_rdata, 32'h44ADBEEF);

        // MISALIGN_EN=0 instance: crossing rejected, aligned accepted.
        do_req(1'b1, 1'b0, F3_W, 32'h2, 32'h0);
        check("na_lw2_lat",   32'(lat),     32'd1);
        check("na_lw2_err",   32'(rsp_err), 32'd1);
        check("na_lw2_beats", 32'(nbeats),  32'd0);
        do_req(1'b1, 1'b0, F3_W, 32'h4, 32'h0);
        check("na_lw4_lat", 32'(lat),     32'd3);
        check("na_lw4_err", 32'(rsp_err), 32'd0);
        use1 = 1'b0;

        // Reset in BEAT1 of a split store.
        @(negedge clk);
        req_wr = 1'b1; req_funct3 = F3_W; req_addr = 32'h31; req_wdata = 32'hCAFEF00D;
        req_valid = 1'b1;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        check("rst_beat0_be", 32'(bus0.mem_be), 32'b1110);
        @(posedge clk);
        #2;
        check("rst_beat1_be", 32'(bus0.mem_be), 32'b0001);
        check("rst_beat1_we", 32'(bus0.mem_we), 32'd1);
        rst_n = 1'b0;
        #1;
        check_reset_outputs("mid");
        repeat (3) begin
            @(negedge clk);
            check("rst_hold_resp_valid", 32'(bus0.resp_valid), 32'd0);
        end
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_release_ready", 32'(bus0.req_ready),  32'd1);
        check("rst_release_resp",  32'(bus0.resp_valid), 32'd0);
        do_req(1'b0, 1'b0, F3_W, 32'h34, 32'h0);
        check("rst_beat1_not_written", rsp_rdata, 32'h0);
        do_req(1'b0, 1'b0, F3_W, 32'h30, 32'h0);
        check("rst_beat0_written", rsp_rdata, 32'hFEF00D00);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/load_store_ctrl.md
LOAD_STORE_CTRL -- requirements
Module: load_store_ctrl

Interface
REQ-001 SHALL have parameter MEM_AW, default 9, meaning word-address width of the attached RAM (depth 2^MEM_AW 32-bit words).
REQ-002 SHALL have parameter MISALIGN_EN, default 1; 1 splits word-crossing accesses into two beats, 0 rejects them with an error.
REQ-003 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_n, input, 1; reset is asynchronous and active-low.
REQ-005 SHALL have port req_valid, input, 1, request present.
REQ-006 SHALL have port req_ready, output, 1, request accepted when req_valid and req_ready are both high at a clock edge.
REQ-007 SHALL have port req_wr, input, 1; 1 is a store, 0 is a load.
REQ-008 SHALL have port req_funct3, input, 3, RISC-V width code: LB/SB=000, LH/SH=001, LW/SW=010, LBU=100, LHU=101.
REQ-009 SHALL have port req_addr, input, 32, byte address.
REQ-010 SHALL have port req_wdata, input, 32, store data, right-aligned.
REQ-011 SHALL have port resp_valid, output, 1, one-cycle completion pulse.
REQ-012 SHALL have port resp_rdata, output, 32, extended load result, valid with resp_valid; 0 for stores and errors.
REQ-013 SHALL have port resp_err, output, 1, illegal or rejected access, valid with resp_valid.
REQ-014 SHALL have ports mem_addr (output, MEM_AW), mem_be (output, 4), mem_we (output, 1), mem_wdata (output, 32), and mem_rdata (input, 32), for a single-port synchronous RAM with 1-cycle read latency.

Function
REQ-015 SHALL use FSM states IDLE, BEAT0, BEAT1, CAPT and RESP; req_ready SHALL be 1 only in IDLE.
REQ-016 SHALL register funct3, addr, wdata and wr on acceptance, then go to BEAT0 unless the request is illegal.
REQ-017 SHALL treat as illegal any load funct3 in {011,110,111}, any store funct3 above 010, and any word-crossing access when MISALIGN_EN=0; illegal requests go IDLE->RESP with resp_err=1 and no memory access.
REQ-018 SHALL define an access as split when addr[1:0]+size exceeds 4 (size 1/2/4 bytes).
REQ-019 SHALL, in BEAT0, drive mem_addr=addr[MEM_AW+1:2] with mem_be equal to the size mask shifted left by addr[1:0], truncated to 4 bits; mem_wdata SHALL be wdata shifted left by 8*addr[1:0].
REQ-020 SHALL, in BEAT1, drive mem_addr+1 (wrapping modulo 2^MEM_AW), the carried-out byte-enable bits, and the carried-out data bytes.
REQ-021 SHALL assert mem_we only in BEAT0/BEAT1 for stores; outside these states mem_be and mem_we SHALL be 0.
REQ-022 SHALL use the following transitions: BEAT0 -> BEAT1 if split; else BEAT0 -> CAPT for a load, or BEAT0 -> RESP for a store. BEAT1 -> CAPT for a load, or BEAT1 -> RESP for a store. CAPT -> RESP. RESP -> IDLE.
REQ-023 SHALL latch the beat-0 read word in the cycle after BEAT0 and the final word in CAPT; the load result is the 64-bit concatenation {word1,word0} shifted right by 8*addr[1:0], truncated to size, then sign-extended (LB/LH) or zero-extended (LBU/LHU).
REQ-024 SHALL produce, for a load accepted at edge T, resp_valid at cycle T+3 (unsplit) or T+4 (split); for a store, T+2 (unsplit) or T+3 (split).
REQ-025 SHALL assert resp_valid only in RESP, exactly one cycle; no response back-pressure exists.
REQ-026 SHALL ignore req_valid while not in IDLE; a request arriving in RESP is accepted no earlier than the following IDLE cycle.

Reset
REQ-027 SHALL, while rst_n=0, force state=IDLE, req_ready=1, resp_valid=0, resp_err=0, resp_rdata=0, mem_we=0, mem_be=0, mem_addr=0 and mem_wdata=0, regardless of clk.
REQ-028 SHALL abandon any in-flight request on reset with no response; a store beat in progress is not completed.

Structure
REQ-029 SHALL take funct3 codes, the state enumeration and size encodings from shared package lsu_pkg.
REQ-030 SHALL place byte-lane shift, merge and extension logic in combinational sub-module lsu_align; the FSM and registers stay in load_store_ctrl.

Verification
REQ-031 SHALL cover this case: SW 0xDEADBEEF at 0x10, then LW at 0x10 -> mem_be=1111 at word 4, resp_rdata=0xDEADBEEF, resp_valid 3 cycles after load accept.
REQ-032 SHALL cover this case: word 8 = 0x000080FF, LB at 0x20 -> 0xFFFFFFFF; LBU at 0x21 -> 0x00000080; LH at 0x20 -> 0xFFFF80FF.
REQ-033 SHALL cover this case: SW 0x11223344 at 0x13 with MISALIGN_EN=1 -> beat0 word 4 with be=1000, beat1 word 5 with be=0111; then LW at 0x13 returns 0x11223344 in 4 cycles.
REQ-034 SHALL cover this case: LH at 0x7FF with MEM_AW=9 -> beat1 mem_addr wraps to 0.
REQ-035 SHALL cover this case: funct3=011 load, and LW at 0x2 with MISALIGN_EN=0 -> resp_err=1, mem_be=0 throughout, response at T+1.
REQ-036 SHALL cover this case: rst_n pulled low during a split store BEAT1 -> outputs reach reset values immediately, no resp_valid, and req_ready=1 after release.
